// File: rtl/dm_arb_pkg.sv
// ---------------------------------------------------------------------------
// dm_arb_pkg
//   Shared definitions for the data-memory port arbiter: the transfer state
//   encoding, beat/byte geometry and the identifiers of the two requesters.
// ---------------------------------------------------------------------------
package dm_arb_pkg;

  // Bytes moved per 64-bit access and the width of one memory beat.
  localparam int BEATS  = 8;
  localparam int BYTE_W = 8;

  // Requester identifiers: port 0 is the CPU load/store path, port 1 the
  // loader/debug path.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  // Transfer sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // waiting for a request
    XFER  = 2'd1,  // one byte beat per cycle on the memory port
    DRAIN = 2'd2,  // read only: collect the last byte after its strobe
    DONE  = 2'd3   // completion pulse to the granted port
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-way round-robin picker. When both ports request, the port that was
//   not granted last wins. The "last granted" pointer is a register that
//   only moves when a grant is actually issued (i_en high and a request
//   present).
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointer resets to
//               port 1 so that port 0 wins the first tie)
//   i_req[1:0]  request per port
//   i_en        picker enabled (arbiter is free to start a transfer)
//   o_gnt[1:0]  one-hot grant, zero when disabled or nothing requested
//   o_last      port granted most recently
// ---------------------------------------------------------------------------
module rr_arb2
  import dm_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt,
  output logic       o_last
);

  logic       r_last;
  logic [1:0] w_pick;

  always_comb begin
    // NOTE: give every combinational output a default before any branch;
    // a path that leaves it unassigned turns the block into a latch.
    w_pick = 2'b00;
    case (i_req)
      2'b01:   w_pick = 2'b01;
      2'b10:   w_pick = 2'b10;
      2'b11:   w_pick = r_last ? 2'b01 : 2'b10;
      default: w_pick = 2'b00;
    endcase
  end

  assign o_gnt  = i_en ? w_pick : 2'b00;
  assign o_last = r_last;

  // NOTE: clocked state is always written with non-blocking assignments so
  // every register samples the pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= PORT_LDR;
    end else if (|o_gnt) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// ---------------------------------------------------------------------------
// dm_port_arbiter
//   Shares the byte-wide data memory between two 64-bit requesters (port 0:
//   CPU load/store, port 1: loader/debug). A granted access is sequenced as
//   BEATS little-endian byte beats starting at the requested byte address,
//   wrapping modulo the memory size. Reads see a one-cycle memory latency,
//   so the last byte is collected in an extra DRAIN cycle.
//
//   Timing from the IDLE cycle in which a request is sampled (cycle 0):
//     write: beats in cycles 1..8, ack in cycle 9
//     read : beats in cycles 1..8, drain in cycle 9, ack in cycle 10
//   DONE always returns to IDLE, so back-to-back accesses are separated by
//   at least one IDLE cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (aborts any
//                     transfer, clears all outputs, no ack)
//   req0/req1         request, held until the matching ack
//   we0/we1           1 = write, 0 = read; sampled at grant
//   addr0/addr1       byte address of byte 0; bits above ADDR_W ignored
//   wdata0/wdata1     write data; sampled at grant
//   rdata0/rdata1     read result, updated only when that port's read ends
//   ack0/ack1         one-cycle completion pulse
//   mem_addr          byte address to the memory
//   mem_wdata         byte to write
//   mem_we / mem_re   byte write / read strobes (never both high)
//   mem_rdata         read byte, valid the cycle after mem_re
// ---------------------------------------------------------------------------
module dm_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int BEATS  = dm_arb_pkg::BEATS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [63:0]          addr0,
  input  logic [63:0]          addr1,
  input  logic [8*BEATS-1:0]   wdata0,
  input  logic [8*BEATS-1:0]   wdata1,
  output logic [8*BEATS-1:0]   rdata0,
  output logic [8*BEATS-1:0]   rdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  output logic                 mem_re,
  input  logic [7:0]           mem_rdata
);

  import dm_arb_pkg::*;

  localparam int DATA_W = BEATS * BYTE_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // ---- registered state --------------------------------------------------
  arb_state_e            r_state;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_port;      // granted port id
  logic                  r_we;        // granted access is a write
  logic [DATA_W-1:0]     r_wdata;     // write bytes not yet sent, LSB first
  logic [DATA_W-1:0]     r_shadow;    // read bytes collected so far
  logic [DATA_W-1:0]     r_rdata0;
  logic [DATA_W-1:0]     r_rdata1;
  logic [1:0]            r_ack;
  logic [ADDR_W-1:0]     r_mem_addr;
  logic [7:0]            r_mem_wdata;
  logic                  r_mem_we;
  logic                  r_mem_re;

  // ---- arbitration and grant-time selection ------------------------------
  logic [1:0]            w_gnt;
  logic                  w_rr_last;
  logic                  w_arb_en;
  logic                  w_sel_we;
  logic [ADDR_W-1:0]     w_sel_addr;
  logic [DATA_W-1:0]     w_sel_wdata;
  logic                  w_unused;

  // Only the IDLE state may start a new transfer; requests arriving while a
  // transfer is running simply stay pending at the picker inputs.
  assign w_arb_en = (r_state == IDLE);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  ({req1, req0}),
    .i_en   (w_arb_en),
    .o_gnt  (w_gnt),
    .o_last (w_rr_last)
  );

  assign w_sel_we    = w_gnt[1] ? we1                 : we0;
  assign w_sel_addr  = w_gnt[1] ? addr1[ADDR_W-1:0]   : addr0[ADDR_W-1:0];
  assign w_sel_wdata = w_gnt[1] ? wdata1              : wdata0;

  // Address bits above the memory size carry no meaning here.
  assign w_unused = ^{addr0[63:ADDR_W], addr1[63:ADDR_W], w_rr_last};

  // ---- transfer sequencer ------------------------------------------------
  // The memory strobes are registered: they are set on the edge that enters
  // a beat and cleared on the edge that leaves the last beat, so the bus is
  // quiet in every state except XFER. Read bytes arrive one cycle after
  // their strobe and are shifted into r_shadow from the top, so after
  // BEATS shifts byte 0 sits in the least significant lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_port      <= PORT_CPU;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_shadow    <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_ack       <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_gnt) begin
            r_port      <= w_gnt[1];
            r_we        <= w_sel_we;
            r_beat      <= '0;
            r_mem_addr  <= w_sel_addr;
            r_mem_we    <= w_sel_we;
            r_mem_re    <= ~w_sel_we;
            r_mem_wdata <= w_sel_we ? w_sel_wdata[BYTE_W-1:0] : 8'h00;
            r_wdata     <= w_sel_wdata >> BYTE_W;
            r_state     <= XFER;
          end
        end

        XFER: begin
          // The byte strobed in the previous beat is on mem_rdata now.
          if (!r_we && (r_beat != '0)) begin
            r_shadow <= {mem_rdata, r_shadow[DATA_W-1:BYTE_W]};
          end

          if (r_beat == LAST_BEAT) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            if (r_we) begin
              r_ack[r_port] <= 1'b1;
              r_state       <= DONE;
            end else begin
              r_state       <= DRAIN;
            end
          end else begin
            r_beat     <= r_beat + BEAT_W'(1);
            r_mem_addr <= r_mem_addr + ADDR_W'(1);
            if (r_we) begin
              r_mem_wdata <= r_wdata[BYTE_W-1:0];
              r_wdata     <= r_wdata >> BYTE_W;
            end
          end
        end

        DRAIN: begin
          // Final byte lands directly in the port's result register.
          if (r_port == PORT_LDR) begin
            r_rdata1 <= {mem_rdata, r_shadow[DATA_W-1:BYTE_W]};
          end else begin
            r_rdata0 <= {mem_rdata, r_shadow[DATA_W-1:BYTE_W]};
          end
          r_ack[r_port] <= 1'b1;
          r_state       <= DONE;
        end

        DONE: begin
          r_ack   <= 2'b00;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // ---- outputs -----------------------------------------------------------
  assign ack0      = r_ack[0];
  assign ack1      = r_ack[1];
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_port_arbiter
//   Directed bench for dm_port_arbiter with a byte memory model (one-cycle
//   read latency). Stimulus pushes the expected memory beats and completion
//   acks into queues; two monitors pop and compare whenever the DUT drives a
//   beat or an ack.
// ---------------------------------------------------------------------------
module tb_dm_port_arbiter;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic              we0 = 1'b0, we1 = 1'b0;
  logic [63:0]       addr0 = '0, addr1 = '0;
  logic [63:0]       wdata0 = '0, wdata1 = '0;
  logic [63:0]       rdata0, rdata1;
  logic              ack0, ack1;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_we, mem_re;
  logic [7:0]        mem_rdata;

  always #5 clk = ~clk;

  dm_port_arbiter #(.ADDR_W(ADDR_W), .BEATS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .ack0      (ack0),
    .ack1      (ack1),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  // ---- memory model: write on strobe, read data one cycle later ----------
  logic [7:0] mem_arr [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= mem_wdata;
    mem_rdata <= mem_re ? mem_arr[mem_addr] : 8'h00;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- scoreboard --------------------------------------------------------
  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    int                cyc;
  } beat_t;

  typedef struct {
    logic        port;
    logic        rd;
    logic [63:0] rdata;
    int          cyc;
  } ack_t;

  beat_t       beat_q[$];
  ack_t        ack_q[$];
  logic [63:0] rdata_model [2];
  int          errors = 0;
  int          checks = 0;
  int          acks_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  // Queue the expected bus beats (and optionally the ack) of one access whose
  // request is sampled in cycle g. For reads, data is the expected result.
  task automatic push_access(input logic port, input logic we, input logic [63:0] addr,
                             input logic [63:0] data, input int g, input int nbeats,
                             input bit with_ack);
    beat_t b;
    ack_t  a;
    for (int k = 0; k < nbeats; k++) begin
      b.we    = we;
      b.addr  = addr[ADDR_W-1:0] + ADDR_W'(k);
      b.wdata = we ? data[8*k +: 8] : 8'h00;
      b.cyc   = g + 1 + k;
      beat_q.push_back(b);
    end
    if (with_ack) begin
      a.port  = port;
      a.rd    = ~we;
      a.rdata = data;
      a.cyc   = g + (we ? 9 : 10);
      ack_q.push_back(a);
    end
  endtask

  // Bus monitor: every strobe must match the next queued beat.
  always @(negedge clk) begin
    if (rst_n && (mem_we || mem_re)) begin
      beat_t b;
      check("we_re_exclusive", mem_we & mem_re, 0);
      if (beat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got addr 0x%0h we %0d expected no beat (cyc=%0d)",
                 mem_addr, mem_we, cyc);
      end else begin
        b = beat_q.pop_front();
        check("beat_cycle", cyc, b.cyc);
        check("beat_we", mem_we, b.we);
        check("beat_addr", mem_addr, b.addr);
        if (b.we) check("beat_wdata", mem_wdata, b.wdata);
      end
    end
  end

  // Ack monitor: order, cycle and read data of every completion.
  always @(negedge clk) begin
    if (rst_n && (ack0 || ack1)) begin
      ack_t a;
      acks_seen++;
      check("ack_onehot", ack0 & ack1, 0);
      if (ack_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack0=%0d ack1=%0d expected none (cyc=%0d)",
                 ack0, ack1, cyc);
      end else begin
        a = ack_q.pop_front();
        check("ack_port", ack1, a.port);
        check("ack_cycle", cyc, a.cyc);
        if (a.rd) rdata_model[a.port] = a.rdata;
        check("rdata0", rdata0, rdata_model[0]);
        check("rdata1", rdata1, rdata_model[1]);
      end
    end
  end

  // ---- stimulus helpers --------------------------------------------------
  task automatic drive(input int p, input logic r, input logic w,
                       input logic [63:0] a, input logic [63:0] d);
    if (p == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  // Returns on the falling edge where the port's ack is seen.
  task automatic wait_ack(input int p);
    int  n = 0;
    logic hit;
    do begin
      @(negedge clk);
      n++;
      hit = (p == 0) ? ack0 : ack1;
    end while (!hit && n < 200);
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack%0d expected one within 200 cycles", p);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem"}, {mem_we, mem_re, mem_addr, mem_wdata}, 0);
    check({tag, "_ack"}, {ack0, ack1}, 0);
    check({tag, "_rdata0"}, rdata0, 0);
    check({tag, "_rdata1"}, rdata1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---- directed sequence -------------------------------------------------
  initial begin
    int c;
    int seen;
    rdata_model[0] = '0;
    rdata_model[1] = '0;

    // Reset state.
    #23;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Both ports requesting from reset: grants 0,1,0,1, ten cycles apart.
    c = cyc;
    push_access(0, 1, 64'h40, 64'h1111_2222_3333_4444, c,      8, 1);
    push_access(1, 1, 64'h48, 64'h5555_6666_7777_8888, c + 10, 8, 1);
    push_access(0, 1, 64'h50, 64'h9999_AAAA_BBBB_CCCC, c + 20, 8, 1);
    push_access(1, 1, 64'h58, 64'hDDDD_EEEE_FFFF_0123, c + 30, 8, 1);
    drive(0, 1, 1, 64'h40, 64'h1111_2222_3333_4444);
    drive(1, 1, 1, 64'h48, 64'h5555_6666_7777_8888);
    wait_ack(0);
    drive(0, 1, 1, 64'h50, 64'h9999_AAAA_BBBB_CCCC);
    wait_ack(1);
    drive(1, 1, 1, 64'h58, 64'hDDDD_EEEE_FFFF_0123);
    wait_ack(0);
    drive(0, 0, 0, 64'h0, 64'h0);
    wait_ack(1);
    drive(1, 0, 0, 64'h0, 64'h0);
    @(negedge clk);

    // Port 0 write at 0x10: bytes 0x01..0x08 on 0x10..0x17, ack in cycle 9.
    c = cyc;
    push_access(0, 1, 64'h10, 64'h0807_0605_0403_0201, c, 8, 1);
    drive(0, 1, 1, 64'h10, 64'h0807_0605_0403_0201);
    wait_ack(0);
    drive(0, 0, 0, 64'h0, 64'h0);
    @(negedge clk);

    // Port 0 read back: ack in cycle 10, rdata1 untouched.
    c = cyc;
    push_access(0, 0, 64'h10, 64'h0807_0605_0403_0201, c, 8, 1);
    drive(0, 1, 0, 64'h10, 64'h0);
    wait_ack(0);
    drive(0, 0, 0, 64'h0, 64'h0);
    @(negedge clk);

    // Port 1 write wrapping past the top of memory, upper address bits set.
    c = cyc;
    push_access(1, 1, 64'hFFFF_FFFF_FFFF_FFFD, 64'h1122_3344_5566_7788, c, 8, 1);
    drive(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFD, 64'h1122_3344_5566_7788);
    wait_ack(1);
    drive(1, 0, 0, 64'h0, 64'h0);
    @(negedge clk);

    // Reset during cycle 4 of a write: only beats 0..2 are observed, outputs
    // clear at once and no ack follows.
    c = cyc;
    push_access(0, 1, 64'h100, 64'hDEAD_BEEF_DEAD_BEEF, c, 3, 0);
    drive(0, 1, 1, 64'h100, 64'hDEAD_BEEF_DEAD_BEEF);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    check("abort_beats_consumed", beat_q.size(), 0);
    drive(0, 0, 0, 64'h0, 64'h0);
    beat_q.delete();
    rdata_model[0] = '0;
    rdata_model[1] = '0;
    seen = acks_seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_ack", acks_seen - seen, 0);

    // Port 0 is served normally after reset.
    c = cyc;
    push_access(0, 1, 64'h100, 64'hA7A6_A5A4_A3A2_A1A0, c, 8, 1);
    drive(0, 1, 1, 64'h100, 64'hA7A6_A5A4_A3A2_A1A0);
    wait_ack(0);
    drive(0, 0, 0, 64'h0, 64'h0);
    @(negedge clk);

    // Port 1 raises during a port 0 read; port 0 re-requests right after its
    // ack and must wait for port 1.
    c = cyc;
    push_access(0, 0, 64'h3FD, 64'h1122_3344_5566_7788, c,      8, 1);
    push_access(1, 0, 64'h10,  64'h0807_0605_0403_0201, c + 11, 8, 1);
    push_access(0, 0, 64'h100, 64'hA7A6_A5A4_A3A2_A1A0, c + 22, 8, 1);
    drive(0, 1, 0, 64'h3FD, 64'h0);
    repeat (3) @(negedge clk);
    drive(1, 1, 0, 64'h10, 64'h0);
    wait_ack(0);
    drive(0, 1, 0, 64'h100, 64'h0);
    wait_ack(1);
    drive(1, 0, 0, 64'h0, 64'h0);
    wait_ack(0);
    drive(0, 0, 0, 64'h0, 64'h0);

    repeat (4) @(negedge clk);
    check("beats_outstanding", beat_q.size(), 0);
    check("acks_outstanding", ack_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single byte-wide data memory between two 64-bit requesters: port 0 is the CPU load/store path, port 1 is the loader/debug path.
- Round-robin arbitration between the two ports.
- Each granted 64-bit access is sequenced as 8 byte beats on the memory port, little-endian.
- Sits between the datapath MEM stage and the data memory array.

Parameters:
- ADDR_W, 10, byte-address width of the memory (1024 bytes).
- BEATS, 8, bytes per access.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0, req1  in  1  access request; must stay high until the matching ack.
- we0, we1  in  1  1 = write, 0 = read; sampled at grant.
- addr0, addr1  in  64  byte address of byte 0; sampled at grant.
- wdata0, wdata1  in  64  write data; sampled at grant.
- rdata0, rdata1  out  64  read result; valid in the ack cycle, held until that port's next read completes.
- ack0, ack1  out  1  one-cycle completion pulse.
- mem_addr  out  ADDR_W  byte address to the memory.
- mem_wdata  out  8  byte to write.
- mem_we  out  1  byte write strobe.
- mem_re  out  1  byte read strobe.
- mem_rdata  in  8  read byte; valid the cycle after mem_re.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, beat=0, rr_last=1 (port 0 wins first).
  - All outputs 0, including rdata0/rdata1.
- States: IDLE, XFER, DRAIN, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port != rr_last.
  - On grant: latch port id, we, addr[ADDR_W-1:0], wdata; set beat=0; go to XFER; update rr_last.
- XFER (BEATS cycles, beat k = 0..7):
  - mem_addr = (addr + k) mod 2^ADDR_W; wraps from 1023 to 0; address bits above ADDR_W are ignored.
  - Write: mem_we=1, mem_wdata = wdata[8k+7:8k].
  - Read: mem_re=1. For k>=1, capture mem_rdata into shadow[8(k-1)+7:8(k-1)].
  - After k=7: write goes to DONE; read goes to DRAIN.
- DRAIN (read only, 1 cycle): mem_re=0; capture mem_rdata into shadow[63:56]; go to DONE.
- DONE (1 cycle):
  - ack of the granted port = 1.
  - On a read, rdata of that port = shadow; the transfer is complete.
  - Go to IDLE.
- Latency from the cycle a request is sampled in IDLE (cycle 0):
  - Write beats in cycles 1..8, ack in cycle 9.
  - Read beats in cycles 1..8, drain in cycle 9, ack in cycle 10.
  - Minimum 1 IDLE cycle between back-to-back accesses.
- Misaligned addresses are legal; there is no alignment check.
- mem_we and mem_re are never high together; mem_* outputs are 0 outside XFER.
- req dropped mid-transfer: the transfer still completes and ack is still pulsed.
- Request from the other port during a transfer: held pending; served next under round-robin.
- Reset mid-transfer: abort immediately. A partial write may remain in memory; no ack is issued.
- The non-granted port's ack and rdata never change.

Decomposition:
- Package dm_arb_pkg:
  - State enum {IDLE, XFER, DRAIN, DONE}.
  - BEATS constant.
  - Port-id localparams.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], last, en.
  - Outputs: gnt[1:0], new last.
  - Purely registered pointer update when en=1.

Test Plan:
- Port 0 write, addr=0x10, wdata=0x0807060504030201:
  - mem_we high in cycles 1..8 with mem_addr 0x10..0x17 and mem_wdata 0x01..0x08.
  - ack0 in cycle 9.
- Port 0 read of the same address, memory model with 1-cycle latency:
  - ack0 in cycle 10.
  - rdata0 = 0x0807060504030201.
  - rdata1 unchanged.
- req0 and req1 asserted together from reset, both held:
  - Grants alternate 0,1,0,1.
  - Each port's ack sequence is 1 pulse per grant.
  - No two transfers overlap.
- Port 1 write at addr=0x3FD:
  - mem_addr sequence 0x3FD, 0x3FE, 0x3FF, 0x000..0x004.
  - Address bits [63:10] set to 1 have no effect.
- rst_n pulled low in cycle 4 of a write:
  - All outputs are 0 within the same cycle (asynchronous reset).
  - No ack is issued.
  - Next request from port 0 is granted normally after rst_n rises.
- req1 raised during a port 0 read, req0 re-raised immediately after ack0:
  - Port 1 is granted next (round-robin).
  - Port 0 waits for port 1's ack.
